// File: rtl/vgalcd_pkg.sv
// Shared types and default widths for the VGA/LCD timing generator.
package vgalcd_pkg;

  localparam int DEF_TB_WIDTH  = 10;
  localparam int DEF_VB_WIDTH  = 16;
  localparam int DEF_DIV_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 12;

  // Phase encoding is shared with the CSR status view, so keep the values fixed.
  typedef enum logic [1:0] {
    BACKPORCH  = 2'b00,
    VISIBLE    = 2'b01,
    FRONTPORCH = 2'b10,
    SYNC       = 2'b11
  } timfsm_e;

  // Timing fields as held for one frame (default-width configuration).
  typedef struct packed {
    logic [DEF_TB_WIDTH-1:0]  hsn;
    logic [DEF_TB_WIDTH-1:0]  hbp;
    logic [DEF_TB_WIDTH-1:0]  hfp;
    logic [DEF_TB_WIDTH-1:0]  vsn;
    logic [DEF_TB_WIDTH-1:0]  vbp;
    logic [DEF_TB_WIDTH-1:0]  vfp;
    logic [DEF_VB_WIDTH-1:0]  hvlen;
    logic [DEF_VB_WIDTH-1:0]  vvlen;
    logic [DEF_DIV_WIDTH-1:0] div;
    logic [DEF_CNT_WIDTH-1:0] lcmp;
  } timing_shadow_t;

  // Phase order: SYNC -> BACKPORCH -> VISIBLE -> FRONTPORCH -> SYNC.
  function automatic timfsm_e next_phase(input timfsm_e s);
    case (s)
      SYNC:       return BACKPORCH;
      BACKPORCH:  return VISIBLE;
      VISIBLE:    return FRONTPORCH;
      FRONTPORCH: return SYNC;
      default:    return SYNC;
    endcase
  endfunction

endpackage

// File: rtl/vgalcd_timphase.sv
// One phase sequencer: walks SYNC/BACKPORCH/VISIBLE/FRONTPORCH, each phase
// lasting its length field + 1 steps. Used for both H (pixel steps) and V
// (line steps). The counter is as wide as the visible field so every legal
// length terminates exactly.
module vgalcd_timphase
  import vgalcd_pkg::*;
#(
  parameter int TB_WIDTH = DEF_TB_WIDTH,
  parameter int VB_WIDTH = DEF_VB_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                srst_i,
  input  logic                step_i,
  input  logic [TB_WIDTH-1:0] sync_len_i,
  input  logic [TB_WIDTH-1:0] bp_len_i,
  input  logic [VB_WIDTH-1:0] vis_len_i,
  input  logic [TB_WIDTH-1:0] fp_len_i,
  output timfsm_e             state_o,
  output logic [VB_WIDTH-1:0] cnt_o,
  output logic                last_o
);

  localparam int PAD = VB_WIDTH - TB_WIDTH;
  localparam logic [VB_WIDTH-1:0] ONE = {{(VB_WIDTH-1){1'b0}}, 1'b1};

  timfsm_e             state_r;
  logic [VB_WIDTH-1:0] cnt_r;
  logic [VB_WIDTH-1:0] len_s;
  logic                phase_end_s;

  // Select the length of the phase currently being walked.
  always_comb begin
    len_s = '0;
    case (state_r)
      SYNC:       len_s = {{PAD{1'b0}}, sync_len_i};
      BACKPORCH:  len_s = {{PAD{1'b0}}, bp_len_i};
      VISIBLE:    len_s = vis_len_i;
      FRONTPORCH: len_s = {{PAD{1'b0}}, fp_len_i};
      default:    len_s = '0;
    endcase
  end

  assign phase_end_s = (cnt_r == len_s);

  // Advance the in-phase counter, moving to the next phase after its last step.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= SYNC;
      cnt_r   <= '0;
    end else if (srst_i) begin
      state_r <= SYNC;
      cnt_r   <= '0;
    end else if (step_i) begin
      if (phase_end_s) begin
        state_r <= next_phase(state_r);
        cnt_r   <= '0;
      end else begin
        cnt_r   <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign state_o = state_r;
  assign cnt_o   = cnt_r;
  assign last_o  = (state_r == FRONTPORCH) && phase_end_s;

endmodule

// File: rtl/vgalcd_timgen.sv
// H/V video timing generator: pixel divider, frame-boundary shadowing of the
// CSR timing fields, H and V phase sequencers and registered outputs.
// Sync/blank polarity is applied after the output registers so the reset
// levels track the polarity inputs directly.
module vgalcd_timgen
  import vgalcd_pkg::*;
#(
  parameter int TB_WIDTH  = DEF_TB_WIDTH,
  parameter int VB_WIDTH  = DEF_VB_WIDTH,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [TB_WIDTH-1:0]  hsn_i,
  input  logic [TB_WIDTH-1:0]  hbp_i,
  input  logic [TB_WIDTH-1:0]  hfp_i,
  input  logic [TB_WIDTH-1:0]  vsn_i,
  input  logic [TB_WIDTH-1:0]  vbp_i,
  input  logic [TB_WIDTH-1:0]  vfp_i,
  input  logic [VB_WIDTH-1:0]  hvlen_i,
  input  logic [VB_WIDTH-1:0]  vvlen_i,
  input  logic                 hspol_i,
  input  logic                 vspol_i,
  input  logic                 blpol_i,
  input  logic [CNT_WIDTH-1:0] lcmp_i,
  output logic                 pclk_en_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 de_o,
  output logic [CNT_WIDTH-1:0] x_o,
  output logic [CNT_WIDTH-1:0] y_o,
  output logic                 hint_o,
  output logic                 vint_o,
  output logic                 lint_o,
  output logic                 frame_o
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Clamp a phase count into the coordinate width instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [VB_WIDTH-1:0] v);
    if (|v[VB_WIDTH-1:CNT_WIDTH]) return {CNT_WIDTH{1'b1}};
    else return v[CNT_WIDTH-1:0];
  endfunction

  // Shadowed timing fields, stable for a whole frame.
  logic [DIV_WIDTH-1:0] div_r;
  logic [TB_WIDTH-1:0]  hsn_r, hbp_r, hfp_r, vsn_r, vbp_r, vfp_r;
  logic [VB_WIDTH-1:0]  hvlen_r, vvlen_r;
  logic [CNT_WIDTH-1:0] lcmp_r;

  logic                 active_r;
  logic [DIV_WIDTH-1:0] dcnt_r;
  logic [CNT_WIDTH-1:0] line_r;

  // Raw (polarity-free) output registers.
  logic                 pclk_r, hsync_r, vsync_r, de_r;
  logic                 hint_r, vint_r, lint_r, frame_r;
  logic [CNT_WIDTH-1:0] x_r, y_r;

  timfsm_e              hs_s, vs_s;
  logic [VB_WIDTH-1:0]  hcnt_s, vcnt_s;
  logic                 h_last_s, v_last_s;
  logic                 srst_s, run_s, tick_s, first_s;
  logic                 line_end_s, frame_end_s, load_s, vis_s;
  logic                 hint_s, vint_s, lint_s, frame_s;

  // Dropping en_i is a synchronous return to the reset state. The first
  // enabled cycle only captures the shadows; the raster starts one cycle later.
  assign srst_s      = ~en_i;
  assign run_s       = en_i & active_r;
  assign tick_s      = run_s & (dcnt_r == div_r);
  assign first_s     = run_s & (dcnt_r == {DIV_WIDTH{1'b0}});
  assign line_end_s  = tick_s & h_last_s;
  assign frame_end_s = line_end_s & v_last_s;
  assign load_s      = (en_i & ~active_r) | frame_end_s;

  // Track whether the generator has been running since the last enable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) active_r <= 1'b0;
    else          active_r <= en_i;
  end

  // Capture CSR timing fields on enable and at every frame boundary.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_r <= '0; hsn_r <= '0; hbp_r <= '0; hfp_r <= '0;
      vsn_r <= '0; vbp_r <= '0; vfp_r <= '0;
      hvlen_r <= '0; vvlen_r <= '0; lcmp_r <= '0;
    end else if (load_s) begin
      div_r <= div_i; hsn_r <= hsn_i; hbp_r <= hbp_i; hfp_r <= hfp_i;
      vsn_r <= vsn_i; vbp_r <= vbp_i; vfp_r <= vfp_i;
      hvlen_r <= hvlen_i; vvlen_r <= vvlen_i; lcmp_r <= lcmp_i;
    end else begin
      div_r <= div_r;
    end
  end

  // Pixel divider: counts 0..div, tick on the last count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    dcnt_r <= '0;
    else if (srst_s) dcnt_r <= '0;
    else if (tick_s) dcnt_r <= '0;
    else if (run_s)  dcnt_r <= dcnt_r + DIV_ONE;
    else             dcnt_r <= dcnt_r;
  end

  // Absolute line number within the frame, saturating for oversize frames.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)         line_r <= '0;
    else if (srst_s)      line_r <= '0;
    else if (frame_end_s) line_r <= '0;
    else if (line_end_s && (line_r != {CNT_WIDTH{1'b1}})) line_r <= line_r + CNT_ONE;
    else                  line_r <= line_r;
  end

  vgalcd_timphase #(.TB_WIDTH(TB_WIDTH), .VB_WIDTH(VB_WIDTH)) u_hphase (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .srst_i     (srst_s),
    .step_i     (tick_s),
    .sync_len_i (hsn_r),
    .bp_len_i   (hbp_r),
    .vis_len_i  (hvlen_r),
    .fp_len_i   (hfp_r),
    .state_o    (hs_s),
    .cnt_o      (hcnt_s),
    .last_o     (h_last_s)
  );

  vgalcd_timphase #(.TB_WIDTH(TB_WIDTH), .VB_WIDTH(VB_WIDTH)) u_vphase (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .srst_i     (srst_s),
    .step_i     (line_end_s),
    .sync_len_i (vsn_r),
    .bp_len_i   (vbp_r),
    .vis_len_i  (vvlen_r),
    .fp_len_i   (vfp_r),
    .state_o    (vs_s),
    .cnt_o      (vcnt_s),
    .last_o     (v_last_s)
  );

  // Pulses fire on the first clock of the position they describe.
  assign vis_s   = (hs_s == VISIBLE) && (vs_s == VISIBLE);
  assign hint_s  = first_s && vis_s && (hcnt_s == hvlen_r);
  assign vint_s  = hint_s && (vcnt_s == vvlen_r);
  assign lint_s  = first_s && (hs_s == SYNC) && (hcnt_s == {VB_WIDTH{1'b0}}) && (line_r == lcmp_r);
  assign frame_s = first_s && (hs_s == SYNC) && (hcnt_s == {VB_WIDTH{1'b0}})
                   && (vs_s == SYNC) && (vcnt_s == {VB_WIDTH{1'b0}});

  // Register all raster outputs one clock after the internal state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pclk_r <= 1'b0; hsync_r <= 1'b0; vsync_r <= 1'b0; de_r <= 1'b0;
      x_r <= '0; y_r <= '0;
      hint_r <= 1'b0; vint_r <= 1'b0; lint_r <= 1'b0; frame_r <= 1'b0;
    end else if (srst_s || !active_r) begin
      pclk_r <= 1'b0; hsync_r <= 1'b0; vsync_r <= 1'b0; de_r <= 1'b0;
      x_r <= '0; y_r <= '0;
      hint_r <= 1'b0; vint_r <= 1'b0; lint_r <= 1'b0; frame_r <= 1'b0;
    end else begin
      pclk_r  <= tick_s;
      hsync_r <= (hs_s == SYNC);
      vsync_r <= (vs_s == SYNC);
      de_r    <= vis_s;
      x_r     <= vis_s ? sat_cnt(hcnt_s) : {CNT_WIDTH{1'b0}};
      y_r     <= vis_s ? sat_cnt(vcnt_s) : {CNT_WIDTH{1'b0}};
      hint_r  <= hint_s;
      vint_r  <= vint_s;
      lint_r  <= lint_s;
      frame_r <= frame_s;
    end
  end

  assign pclk_en_o = pclk_r;
  assign hsync_o   = hsync_r ^ hspol_i;
  assign vsync_o   = vsync_r ^ vspol_i;
  assign de_o      = de_r ^ blpol_i;
  assign x_o       = x_r;
  assign y_o       = y_r;
  assign hint_o    = hint_r;
  assign vint_o    = vint_r;
  assign lint_o    = lint_r;
  assign frame_o   = frame_r;

endmodule
